// File: rtl/valid_event_counter.sv
// Counts accepted valid strobes with clear, wrap/saturate modes, threshold pulse and sticky overflow.
// Optional embedded assertions are compiled in when VALID_EVENT_COUNTER_SVA_EN is defined.
module valid_event_counter #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] thresh_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] count_prev_o,
  output logic             hit_o,
  output logic             ovf_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam bit             SAT      = (SATURATE != 0);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] PRE_MAX  = {{(WIDTH-1){1'b1}}, 1'b0};

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic [WIDTH-1:0] count_inc;
  logic             refused;

  assign ready_o   = !(SAT && (state == FULL));
  assign accept    = valid_i && ready_o && !clear_i;
  assign count_inc = count_o + ONE;
  // A strobe turned away while saturated is what marks overflow in saturate mode.
  assign refused   = SAT && (state == FULL) && valid_i && !clear_i;
  assign state_o   = state;

  always_comb begin
    state_next = state;
    if (clear_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = RUN;
        RUN:     if (accept && (count_o == PRE_MAX)) state_next = FULL;
        FULL:    if (accept) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count_o      <= '0;
      count_prev_o <= '0;
      hit_o        <= 1'b0;
      ovf_o        <= 1'b0;
    end else begin
      state        <= state_next;
      count_prev_o <= count_o;
      if (clear_i) begin
        count_o <= '0;
        hit_o   <= 1'b0;
        ovf_o   <= 1'b0;
      end else begin
        hit_o <= accept && (count_inc == thresh_i);
        if (accept) begin
          count_o <= count_inc;
        end
        if ((accept && (count_o == ALL_ONES)) || refused) begin
          ovf_o <= 1'b1;
        end
      end
    end
  end

`ifdef VALID_EVENT_COUNTER_SVA_EN
  a_accept_inc: assert property (@(posedge clk) disable iff (!rst_n)
    accept |=> (count_o == ($past(count_o) + ONE)))
    else $error("valid_event_counter: accept did not increment count at %0t", $realtime);

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (!accept && !clear_i) |=> $stable(count_o))
    else $error("valid_event_counter: count changed without accept at %0t", $realtime);

  a_hit_cause: assert property (@(posedge clk) disable iff (!rst_n)
    hit_o |-> $past(accept))
    else $error("valid_event_counter: hit without prior accept at %0t", $realtime);

  a_ready_low: assert property (@(posedge clk) disable iff (!rst_n)
    !ready_o |-> (SAT && (state_o == 2'd2)))
    else $error("valid_event_counter: ready low outside saturated FULL at %0t", $realtime);
`endif

endmodule

// File: tb/tb_valid_event_counter.sv
// Directed bench driving a wrapping and a saturating counter from shared stimulus.
module tb_valid_event_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid;
  logic         clear;
  logic [W-1:0] thresh;

  logic         ready0, ready1;
  logic [W-1:0] count0, count1, prev0, prev1;
  logic         hit0, hit1, ovf0, ovf1;
  logic [1:0]   st0, st1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  valid_event_counter #(.WIDTH(W), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .ready_o(ready0), .clear_i(clear),
    .thresh_i(thresh), .count_o(count0), .count_prev_o(prev0), .hit_o(hit0),
    .ovf_o(ovf0), .state_o(st0)
  );

  valid_event_counter #(.WIDTH(W), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .ready_o(ready1), .clear_i(clear),
    .thresh_i(thresh), .count_o(count1), .count_prev_o(prev1), .hit_o(hit1),
    .ovf_o(ovf1), .state_o(st1)
  );

  typedef struct {
    logic         valid;
    logic         clear;
    logic [W-1:0] thresh;
    logic [W-1:0] count;
    logic [W-1:0] prev;
    logic         hit;
    logic [1:0]   state;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic v, input logic c, input logic [W-1:0] t,
                        input logic [W-1:0] ec, input logic [W-1:0] ep,
                        input logic eh, input logic [1:0] es);
    vec_t x;
    x.valid = v; x.clear = c; x.thresh = t;
    x.count = ec; x.prev = ep; x.hit = eh; x.state = es;
    vecs.push_back(x);
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int dut,
                             input logic [W-1:0] ec, input logic [W-1:0] ep,
                             input logic eh, input logic eo,
                             input logic [1:0] es, input logic er);
    string t;
    t = $sformatf("%s.%s", tag, (dut == 0) ? "wrap" : "sat");
    if (dut == 0) begin
      checkVal({t, ".count"}, 32'(count0), 32'(ec));
      checkVal({t, ".prev"},  32'(prev0),  32'(ep));
      checkVal({t, ".hit"},   32'(hit0),   32'(eh));
      checkVal({t, ".ovf"},   32'(ovf0),   32'(eo));
      checkVal({t, ".state"}, 32'(st0),    32'(es));
      checkVal({t, ".ready"}, 32'(ready0), 32'(er));
    end else begin
      checkVal({t, ".count"}, 32'(count1), 32'(ec));
      checkVal({t, ".prev"},  32'(prev1),  32'(ep));
      checkVal({t, ".hit"},   32'(hit1),   32'(eh));
      checkVal({t, ".ovf"},   32'(ovf1),   32'(eo));
      checkVal({t, ".state"}, 32'(st1),    32'(es));
      checkVal({t, ".ready"}, 32'(ready1), 32'(er));
    end
  endtask

  // Inputs change on the falling edge; outputs are read 1 ns after the rising edge.
  task automatic applyStimulus(input logic v, input logic c, input logic [W-1:0] t);
    @(negedge clk);
    valid  = v;
    clear  = c;
    thresh = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; clear = 1'b0; thresh = '0;

    // valid, clear, thresh -> count, prev, hit, state (ovf 0, ready 1 throughout)
    addVec(1, 0, 0, 1, 0, 0, 1);
    addVec(0, 0, 0, 1, 1, 0, 1);
    addVec(1, 0, 0, 2, 1, 0, 1);
    addVec(0, 0, 0, 2, 2, 0, 1);
    addVec(1, 0, 0, 3, 2, 0, 1);
    addVec(0, 0, 0, 3, 3, 0, 1);
    addVec(0, 1, 0, 0, 3, 0, 0);
    addVec(1, 0, 0, 1, 0, 0, 1);
    addVec(1, 0, 0, 2, 1, 0, 1);
    addVec(1, 0, 0, 3, 2, 0, 1);
    addVec(1, 0, 0, 4, 3, 0, 1);
    addVec(1, 0, 0, 5, 4, 0, 1);
    addVec(0, 0, 0, 5, 5, 0, 1);
    addVec(0, 0, 0, 5, 5, 0, 1);
    addVec(0, 0, 0, 5, 5, 0, 1);
    addVec(0, 1, 0, 0, 5, 0, 0);
    addVec(1, 0, 4, 1, 0, 0, 1);
    addVec(1, 0, 4, 2, 1, 0, 1);
    addVec(1, 0, 4, 3, 2, 0, 1);
    addVec(1, 0, 4, 4, 3, 1, 1);
    addVec(1, 0, 4, 5, 4, 0, 1);
    addVec(1, 0, 4, 6, 5, 0, 1);
    addVec(0, 0, 4, 6, 6, 0, 1);
    addVec(1, 0, 0, 7, 6, 0, 1);
    addVec(1, 1, 8, 0, 7, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 0, 0, 0, 0, 0, 0, 1);
    checkOutput("reset", 1, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].valid, vecs[i].clear, vecs[i].thresh);
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("vec%0d", i), d, vecs[i].count, vecs[i].prev,
                    vecs[i].hit, 1'b0, vecs[i].state, 1'b1);
      end
    end

    // Asynchronous reset in the middle of a burst.
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("burst3", 0, 3, 2, 0, 0, 1, 1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst", 0, 0, 0, 0, 0, 0, 1);
    checkOutput("async_rst", 1, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst", 0, 1, 0, 0, 0, 1, 1);
    checkOutput("post_rst", 1, 1, 0, 0, 0, 1, 1);

    applyStimulus(0, 1, 0);
    checkOutput("clr2", 0, 0, 1, 0, 0, 0, 1);

    // Preload to 254, then walk through the top of the range in both modes.
    for (int i = 0; i < 254; i++) applyStimulus(1, 0, 0);
    checkOutput("pre254", 0, 254, 253, 0, 0, 1, 1);
    checkOutput("pre254", 1, 254, 253, 0, 0, 1, 1);

    applyStimulus(1, 0, 0);
    checkOutput("to255", 0, 255, 254, 0, 0, 2, 1);
    checkOutput("to255", 1, 255, 254, 0, 0, 2, 0);

    applyStimulus(1, 0, 0);
    checkOutput("wrap0", 0, 0, 255, 1, 1, 1, 1);
    checkOutput("refuse1", 1, 255, 255, 0, 1, 2, 0);

    applyStimulus(1, 0, 0);
    checkOutput("wrap1", 0, 1, 0, 0, 1, 1, 1);
    checkOutput("refuse2", 1, 255, 255, 0, 1, 2, 0);

    applyStimulus(0, 0, 0);
    checkOutput("sticky", 0, 1, 1, 0, 1, 1, 1);
    checkOutput("sticky", 1, 255, 255, 0, 1, 2, 0);

    applyStimulus(0, 1, 0);
    checkOutput("clr_full", 0, 0, 1, 0, 0, 0, 1);
    checkOutput("clr_full", 1, 0, 255, 0, 0, 0, 1);

    applyStimulus(1, 0, 0);
    checkOutput("resume", 0, 1, 0, 0, 0, 1, 1);
    checkOutput("resume", 1, 1, 0, 0, 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
